// File: rtl/sirv_icb_line_xfer_mst.sv
// sirv_icb_line_xfer_mst: ICB initiator that moves one cache line per request as single-beat reads or writes
module sirv_icb_line_xfer_mst #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int MW = DW / 8,
  parameter int LINE_WORDS = 8,
  parameter int OUTS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [AW-1:0]            req_addr,
  input  logic [LINE_WORDS*DW-1:0] req_wdata,
  output logic                     done_valid,
  input  logic                     done_ready,
  output logic [LINE_WORDS*DW-1:0] done_rdata,
  output logic                     done_err,
  output logic                     o_icb_cmd_valid,
  input  logic                     o_icb_cmd_ready,
  output logic                     o_icb_cmd_read,
  output logic [AW-1:0]            o_icb_cmd_addr,
  output logic [DW-1:0]            o_icb_cmd_wdata,
  output logic [MW-1:0]            o_icb_cmd_wmask,
  input  logic                     o_icb_rsp_valid,
  output logic                     o_icb_rsp_ready,
  input  logic [DW-1:0]            o_icb_rsp_rdata,
  input  logic                     o_icb_rsp_err
);
  localparam int LB = $clog2(LINE_WORDS);
  localparam int CW = LB + 1;
  localparam int OW = $clog2(OUTS + 1);
  localparam int BB = $clog2(MW);
  localparam logic [CW-1:0] LW = CW'(LINE_WORDS);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  localparam logic [OW-1:0] OM = OW'(OUTS);
  localparam logic [AW-1:0] BASE_MASK = ~((AW'(1) << (LB + BB)) - AW'(1));
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cmd_cnt, rsp_cnt;
  logic [OW-1:0] out_cnt;
  logic [AW-1:0] base;
  logic wr, err;
  logic [DW-1:0] line [LINE_WORDS];
  logic req_hs, cmd_hs, rsp_hs, last_rsp;
  assign req_hs = req_valid & req_ready;
  assign cmd_hs = o_icb_cmd_valid & o_icb_cmd_ready;
  // responses outside BUSY are strays from an interrupted transfer and are dropped
  assign rsp_hs = (state == BUSY) & o_icb_rsp_valid;
  assign last_rsp = rsp_hs & (rsp_cnt == LAST);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = (state == IDLE && req_valid) ? BUSY :
                last_rsp ? DONE :
                (state == DONE && done_ready) ? IDLE : state;
  end
  always_comb begin
    req_ready = state == IDLE;
    done_valid = state == DONE;
    done_err = done_valid & err;
    o_icb_cmd_valid = (state == BUSY) & (cmd_cnt < LW) & (out_cnt < OM);
    o_icb_cmd_read = ~wr;
    o_icb_cmd_addr = base + (AW'(cmd_cnt[LB-1:0]) << BB);
    o_icb_cmd_wdata = line[cmd_cnt[LB-1:0]];
    o_icb_cmd_wmask = '1;
    o_icb_rsp_ready = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_cnt <= '0;
      rsp_cnt <= '0;
      out_cnt <= '0;
      err <= 1'b0;
      wr <= 1'b0;
      base <= '0;
    end else if (req_hs) begin
      cmd_cnt <= '0;
      rsp_cnt <= '0;
      out_cnt <= '0;
      err <= 1'b0;
      wr <= req_write;
      base <= req_addr & BASE_MASK;
    end else if (state == BUSY) begin
      cmd_cnt <= cmd_cnt + CW'(cmd_hs);
      rsp_cnt <= rsp_cnt + CW'(rsp_hs);
      out_cnt <= out_cnt + OW'(cmd_hs) - OW'(rsp_hs);
      err <= err | (rsp_hs & o_icb_rsp_err);
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < LINE_WORDS; i++)
      if (req_hs && req_write) line[i] <= req_wdata[i*DW +: DW];
      else if (rsp_hs && !wr && rsp_cnt[LB-1:0] == LB'(i)) line[i] <= o_icb_rsp_rdata;
  end
  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_out
    assign done_rdata[g*DW +: DW] = line[g];
  end
endmodule

// File: tb/tb_sirv_icb_line_xfer_mst.sv
// tb_sirv_icb_line_xfer_mst: directed and randomized line transfers against a queue-based ICB slave and memory model
module tb_sirv_icb_line_xfer_mst;
  localparam int DW = 32, AW = 32, MW = 4, LW = 8, OUTS = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid, req_ready, req_write, done_valid, done_ready, done_err;
  logic [AW-1:0] req_addr;
  logic [LW*DW-1:0] req_wdata, done_rdata;
  logic o_icb_cmd_valid, o_icb_cmd_ready = 1'b0, o_icb_cmd_read;
  logic [AW-1:0] o_icb_cmd_addr;
  logic [DW-1:0] o_icb_cmd_wdata, o_icb_rsp_rdata = '0;
  logic [MW-1:0] o_icb_cmd_wmask;
  logic o_icb_rsp_valid = 1'b0, o_icb_rsp_ready, o_icb_rsp_err = 1'b0;

  sirv_icb_line_xfer_mst #(.DW(DW), .AW(AW), .MW(MW), .LINE_WORDS(LW), .OUTS(OUTS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done_valid(done_valid), .done_ready(done_ready),
    .done_rdata(done_rdata), .done_err(done_err), .o_icb_cmd_valid(o_icb_cmd_valid),
    .o_icb_cmd_ready(o_icb_cmd_ready), .o_icb_cmd_read(o_icb_cmd_read), .o_icb_cmd_addr(o_icb_cmd_addr),
    .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask), .o_icb_rsp_valid(o_icb_rsp_valid),
    .o_icb_rsp_ready(o_icb_rsp_ready), .o_icb_rsp_rdata(o_icb_rsp_rdata), .o_icb_rsp_err(o_icb_rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic rd; logic [31:0] wdata; logic [3:0] wmask; } cmd_t;
  typedef struct { int due; logic [31:0] rdata; logic err; } rsp_t;
  cmd_t log_q[$];
  rsp_t pend_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] salt;
  int cyc = 0, errors = 0, checks = 0;
  int lat = 1, err_beat = -1, stall_left = 0;
  bit rnd = 0;
  int xfer_cmds = 0, outst = 0, max_out = 0, viol = 0, due;
  logic pv = 0, pr = 0, prd = 0, prst = 1;
  logic [31:0] pa = 0, pw = 0;

  task automatic chk(input string tag, input logic [263:0] ob, input logic [263:0] ex);
    checks++;
    if (ob !== ex) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, ob, ex);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  always @(posedge clk) begin
    if (pv && !pr && !prst &&
        !(o_icb_cmd_valid && o_icb_cmd_addr == pa && o_icb_cmd_wdata == pw && o_icb_cmd_read == prd)) viol++;
    pv = o_icb_cmd_valid; pr = o_icb_cmd_ready; pa = o_icb_cmd_addr; pw = o_icb_cmd_wdata;
    prd = o_icb_cmd_read; prst = rst;
    if (o_icb_cmd_valid && o_icb_cmd_ready) begin
      due = cyc + (rnd ? int'($urandom_range(1, 6)) : lat);
      if (pend_q.size() > 0 && pend_q[$].due > due) due = pend_q[$].due;
      log_q.push_back('{addr: o_icb_cmd_addr, rd: o_icb_cmd_read, wdata: o_icb_cmd_wdata, wmask: o_icb_cmd_wmask});
      pend_q.push_back('{due: due, rdata: o_icb_cmd_read ? mrd(o_icb_cmd_addr) : $urandom, err: xfer_cmds == err_beat});
      if (!o_icb_cmd_read) mem[o_icb_cmd_addr] = o_icb_cmd_wdata;
      xfer_cmds++;
      outst++;
    end
    if (o_icb_rsp_valid && o_icb_rsp_ready) begin
      void'(pend_q.pop_front());
      outst--;
    end
    if (outst > max_out) max_out = outst;
    cyc++;
  end

  always @(negedge clk) begin
    o_icb_cmd_ready = stall_left == 0 && (!rnd || $urandom_range(0, 2) != 0);
    if (stall_left > 0) stall_left--;
    o_icb_rsp_valid = pend_q.size() > 0 && pend_q[0].due <= cyc;
    o_icb_rsp_rdata = o_icb_rsp_valid ? pend_q[0].rdata : $urandom;
    o_icb_rsp_err = o_icb_rsp_valid && pend_q[0].err;
  end

  task automatic xfer(input bit w, input logic [31:0] a, input logic [LW*DW-1:0] wd, input int hold,
                      input int stall, input int l, input int eb,
                      output logic [LW*DW-1:0] rd, output logic e, output int dl);
    logic [LW*DW-1:0] ex;
    logic [31:0] base;
    logic ee;
    int t0, n;
    base = a & ~32'h1F;
    ee = eb >= 0 && eb < LW;
    for (int i = 0; i < LW; i++) ex[i*DW +: DW] = w ? wd[i*DW +: DW] : mrd(base + 32'(4 * i));
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = wd;
    #1;
    stall_left = stall; lat = l; err_beat = eb; xfer_cmds = 0; outst = 0; max_out = 0; viol = 0;
    log_q.delete();
    @(negedge clk);
    t0 = cyc;
    req_valid = 0;
    chk("first_cmd_valid", o_icb_cmd_valid, 1'b1);
    n = 0;
    while (!done_valid && n < 500) begin @(negedge clk); n++; end
    dl = cyc - t0 + 1;
    chk("done_timeout", done_valid, 1'b1);
    rd = done_rdata;
    e = done_err;
    chk("done_rdata", rd, ex);
    chk("done_err", e, ee);
    chk("cmd_count", log_q.size(), LW);
    for (int i = 0; i < log_q.size(); i++) begin
      chk("cmd_addr", log_q[i].addr, base + 32'(4 * i));
      chk("cmd_read_wmask", {log_q[i].rd, log_q[i].wmask}, {~w, 4'hF});
      if (w) chk("cmd_wdata", log_q[i].wdata, wd[i*DW +: DW]);
    end
    chk("outstanding_le_outs", max_out <= OUTS, 1'b1);
    chk("cmd_stable_under_stall", viol, 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("done_hold", {done_valid, req_ready, done_err, done_rdata}, {1'b1, 1'b0, e, rd});
    end
    done_ready = 1;
    @(negedge clk);
    done_ready = 0;
    chk("idle_after_done", {req_ready, done_valid}, 2'b10);
  endtask

  initial begin
    logic [LW*DW-1:0] rd, wd;
    logic e;
    int dl, n;
    salt = $urandom;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; done_ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_outputs", {req_ready, done_valid, o_icb_cmd_valid, done_err, o_icb_rsp_ready}, 5'b10001);
    xfer(0, 32'h8000_0010, '0, 0, 0, 1, -1, rd, e, dl);
    chk("refill_latency", dl, LW + 2);
    for (int i = 0; i < LW; i++) wd[i*DW +: DW] = 32'hA0 + 32'(i);
    xfer(1, 32'h4000_1238, wd, 0, 0, 1, -1, rd, e, dl);
    chk("writeback_echo", rd, wd);
    chk("writeback_latency", dl, LW + 2);
    xfer(0, 32'h4000_1220, '0, 0, 0, 1, -1, rd, e, dl);
    chk("readback_after_writeback", rd, wd);
    xfer(0, 32'h0000_2040, '0, 0, 3, 4, -1, rd, e, dl);
    chk("outstanding_reached_outs", max_out, OUTS);
    xfer(0, 32'h1000_0000, '0, 0, 0, 1, 5, rd, e, dl);
    chk("err_all_beats_issued", xfer_cmds, LW);
    xfer(1, 32'h1000_0040, {8{32'h1357_9BDF}}, 5, 0, 1, -1, rd, e, dl);
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 32'h1234_5660;
    #1;
    lat = 4; stall_left = 0; err_beat = -1; xfer_cmds = 0;
    log_q.delete();
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (log_q.size() < 3 && n < 100) begin @(negedge clk); n++; end
    chk("rst_three_cmds_issued", log_q.size() >= 3, 1'b1);
    chk("rst_rsps_outstanding", pend_q.size() > 0, 1'b1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_xfer_outputs", {req_ready, done_valid, o_icb_cmd_valid, done_err, o_icb_rsp_ready}, 5'b10001);
    repeat (12) @(negedge clk);
    chk("strays_drained", pend_q.size(), 0);
    chk("idle_after_strays", {req_ready, done_valid, o_icb_cmd_valid, done_err}, 4'b1000);
    xfer(0, 32'h1234_5660, '0, 0, 0, 1, -1, rd, e, dl);
    #1 rnd = 1;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < LW; i++) wd[i*DW +: DW] = $urandom;
      xfer(t == 0 ? 1'b0 : 1'($urandom_range(0, 1)), t == 0 ? 32'hFFFF_FFF4 : $urandom, wd,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1, int'($urandom_range(0, 8)) - 1, rd, e, dl);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
